// File: rtl/sort_pkg.sv
// Shared definitions for the sorter back-end stages.
//   GROUP_SIZE : number of sorted elements packed into one group word.
//   ptr_w()    : FIFO pointer width. It is one bit wider than the address
//                so that full and empty can be told apart.
package sort_pkg;

    localparam int GROUP_SIZE = 4;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sort_pack_fifo.sv
// Small synchronous FIFO holding completed groups.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr           : synchronous flush. It wins over a same-cycle push/pop.
//   push, wdata   : write one entry. The caller never pushes while full.
//   pop           : drop the head entry. The caller only pops when non-empty.
//   full, empty   : occupancy flags, decoded from the registered pointers only
//   head          : head entry, or all zeros while empty
module sort_pack_fifo
    import sort_pkg::*;
#(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // The storage is not reset. Only the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sort_group_packer.sv
// Packs the sorted element stream into groups of four elements. Each group is
// checked for non-decreasing order and then queued for the consumer.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clr               : synchronous clear of the partial group, the FIFO and the counters
//   in_val/in_rdy     : element handshake. An element transfers on a cycle where
//                       both are high. in_rdy depends on registers only.
//   in_data           : sorted element (DW bits)
//   out_val/out_rdy   : group handshake. A group transfers on a cycle where both
//                       are high. out_val depends on registers only.
//   out_data          : packed group; element k is in [k*DW +: DW]
//   out_err           : the head group was out of order
//   grp_cnt, err_cnt  : wrapping counts of pushed groups and of pushed error groups
module sort_group_packer
    import sort_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_val,
    input  logic [DW-1:0]            in_data,
    output logic                     in_rdy,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [GROUP_SIZE*DW-1:0] out_data,
    output logic                     out_err,
    output logic [CW-1:0]            grp_cnt,
    output logic [CW-1:0]            err_cnt
);

    localparam int GW = GROUP_SIZE * DW;
    localparam int FW = GW + 1;

    logic [1:0]    idx;
    logic [DW-1:0] lane [GROUP_SIZE];
    logic          grp_err;

    logic          accept;
    logic          push;
    logic          pop;
    logic          lane_lt;
    logic          push_err;
    logic [DW-1:0] prev;
    logic          full;
    logic          empty;
    logic [FW-1:0] wdata;
    logic [FW-1:0] head;

    assign accept = in_val && in_rdy;
    assign push   = accept && (idx == 2'd3);
    assign pop    = out_val && out_rdy;

    // Lane 0 has no predecessor. The wrapped lane[3] read on lane 0 is ignored.
    assign prev     = lane[idx - 2'd1];
    assign lane_lt  = (idx != 2'd0) && (in_data < prev);
    assign push_err = grp_err | lane_lt;

    // Lane 3 does not need to be stored first. It goes straight into the FIFO entry.
    assign wdata = {push_err, in_data, lane[2], lane[1], lane[0]};

    // Lanes 0..2 always proceed. Only the lane that completes a group waits for room.
    assign in_rdy   = (idx != 2'd3) || !full;
    assign out_val  = !empty;
    assign out_data = head[GW-1:0];
    assign out_err  = head[GW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= 2'd0;
            grp_err <= 1'b0;
            for (int k = 0; k < GROUP_SIZE; k++) lane[k] <= '0;
        end else if (clr) begin
            idx     <= 2'd0;
            grp_err <= 1'b0;
        end else if (accept) begin
            lane[idx] <= in_data;
            idx       <= idx + 2'd1;
            // Lane 0 starts a new group, so the sticky flag is cleared there.
            grp_err   <= (idx == 2'd0) ? 1'b0 : push_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_cnt <= '0;
            err_cnt <= '0;
        end else if (clr) begin
            grp_cnt <= '0;
            err_cnt <= '0;
        end else if (push) begin
            grp_cnt <= grp_cnt + CW'(1);
            if (push_err) err_cnt <= err_cnt + CW'(1);
        end
    end

    sort_pack_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

endmodule

// File: tb/tb_sort_group_packer.sv
// Bench for sort_group_packer (DW=8, DEPTH=4, CW=16).
// Inputs are driven on the falling edge and outputs are sampled there too,
// halfway between the rising edges where the DUT updates.
module tb_sort_group_packer;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_val;
    logic [7:0]  in_data;
    logic        in_rdy;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_data;
    logic        out_err;
    logic [15:0] grp_cnt;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_grp;
    logic [15:0] exp_err;
    logic [2:0]  occ;

    sort_group_packer #(.DW(8), .DEPTH(4), .CW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_val   (in_val),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_err  (out_err),
        .grp_cnt  (grp_cnt),
        .err_cnt  (err_cnt)
    );

    assign occ = dut.u_fifo.wr_ptr - dut.u_fifo.rd_ptr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  e [4];
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called on a falling edge. Holds the element until it is accepted, with a
    // bound on the wait, and returns on the falling edge after the accept.
    task automatic send(input logic [7:0] d);
        bit done;
        done = 1'b0;
        in_data = d;
        in_val  = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            if (in_rdy) done = 1'b1;
            next_cycle();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_rdy stayed 0 for element 0x%0h", d);
        end
    endtask

    // Checks the head group, then pops it on the next rising edge.
    task automatic expect_pop(input string name, input logic [31:0] d, input logic e);
        check({name, "_val"}, {31'd0, out_val}, 32'd1);
        check({name, "_data"}, out_data, d);
        check({name, "_err"}, {31'd0, out_err}, {31'd0, e});
        out_rdy = 1'b1;
        next_cycle();
    endtask

    initial begin
        vecs[0] = '{e: '{8'd3, 8'd7, 8'd7, 8'd200},      exp_data: 32'hC8070703, exp_err: 1'b0};
        vecs[1] = '{e: '{8'd9, 8'd4, 8'd5, 8'd6},        exp_data: 32'h06050409, exp_err: 1'b1};
        vecs[2] = '{e: '{8'd0, 8'd0, 8'd0, 8'd0},        exp_data: 32'h00000000, exp_err: 1'b0};
        vecs[3] = '{e: '{8'd10, 8'd20, 8'd30, 8'd5},     exp_data: 32'h051E140A, exp_err: 1'b1};
        vecs[4] = '{e: '{8'd255, 8'd255, 8'd255, 8'd255}, exp_data: 32'hFFFFFFFF, exp_err: 1'b0};
        vecs[5] = '{e: '{8'd1, 8'd2, 8'd1, 8'd2},        exp_data: 32'h02010201, exp_err: 1'b1};

        rst_n   = 1'b0;
        clr     = 1'b0;
        in_val  = 1'b0;
        in_data = 8'd0;
        out_rdy = 1'b0;
        exp_grp = 16'd0;
        exp_err = 16'd0;

        // Reset values
        #12;
        check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
        check("rst_out_val", {31'd0, out_val}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_grp_cnt", {16'd0, grp_cnt}, 32'd0);
        check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        check("rst_idx", {30'd0, dut.idx}, 32'd0);
        check("rst_wr_ptr", {29'd0, dut.u_fifo.wr_ptr}, 32'd0);
        check("rst_rd_ptr", {29'd0, dut.u_fifo.rd_ptr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven groups with the consumer always ready
        out_rdy = 1'b1;
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 3; k++) send(vecs[v].e[k]);
            check("tbl_val_before_lane3", {31'd0, out_val}, 32'd0);
            send(vecs[v].e[3]);
            in_val = 1'b0;
            exp_grp = exp_grp + 16'd1;
            if (vecs[v].exp_err) exp_err = exp_err + 16'd1;
            check("tbl_out_val", {31'd0, out_val}, 32'd1);
            check("tbl_out_data", out_data, vecs[v].exp_data);
            check("tbl_out_err", {31'd0, out_err}, {31'd0, vecs[v].exp_err});
            check("tbl_grp_cnt", {16'd0, grp_cnt}, {16'd0, exp_grp});
            check("tbl_err_cnt", {16'd0, err_cnt}, {16'd0, exp_err});
        end
        next_cycle();
        check("tbl_drained", {31'd0, out_val}, 32'd0);

        // Backpressure to full: elements 0..18 go in, element 19 stalls
        out_rdy = 1'b0;
        for (int i = 0; i < 19; i++) send(8'(i));
        in_data = 8'd19;
        in_val  = 1'b1;
        check("bp_in_rdy_low", {31'd0, in_rdy}, 32'd0);
        check("bp_idx", {30'd0, dut.idx}, 32'd3);
        check("bp_occ", {29'd0, occ}, 32'd4);
        check("bp_grp_cnt", {16'd0, grp_cnt}, {16'd0, exp_grp + 16'd4});
        next_cycle();
        check("bp_stall_hold", {31'd0, in_rdy}, 32'd0);
        check("bp_stall_cnt", {16'd0, grp_cnt}, {16'd0, exp_grp + 16'd4});
        out_rdy = 1'b1;
        next_cycle();
        out_rdy = 1'b0;
        check("bp_in_rdy_rise", {31'd0, in_rdy}, 32'd1);
        check("bp_head_after_pop", out_data, 32'h07060504);
        next_cycle();
        in_val  = 1'b0;
        exp_grp = exp_grp + 16'd5;
        check("bp_fifth_push", {16'd0, grp_cnt}, {16'd0, exp_grp});
        check("bp_occ_after", {29'd0, occ}, 32'd4);
        expect_pop("bp_g1", 32'h07060504, 1'b0);
        expect_pop("bp_g2", 32'h0B0A0908, 1'b0);
        expect_pop("bp_g3", 32'h0F0E0D0C, 1'b0);
        expect_pop("bp_g4", 32'h13121110, 1'b0);
        check("bp_empty", {31'd0, out_val}, 32'd0);

        // Push and pop in the same cycle
        out_rdy = 1'b0;
        for (int k = 0; k < 4; k++) send(8'd1);
        for (int k = 0; k < 4; k++) send(8'd2);
        for (int k = 0; k < 3; k++) send(8'd3);
        check("pp_occ_before", {29'd0, occ}, 32'd2);
        out_rdy = 1'b1;
        send(8'd3);
        in_val = 1'b0;
        check("pp_occ_same", {29'd0, occ}, 32'd2);
        expect_pop("pp_b", 32'h02020202, 1'b0);
        expect_pop("pp_c", 32'h03030303, 1'b0);
        check("pp_empty", {31'd0, out_val}, 32'd0);

        // Clear in the middle of a group. The lane-1 drop sets the sticky error first.
        send(8'd50);
        send(8'd40);
        in_data = 8'd70;
        in_val  = 1'b1;
        clr     = 1'b1;
        next_cycle();
        clr    = 1'b0;
        in_val = 1'b0;
        check("clr_idx", {30'd0, dut.idx}, 32'd0);
        check("clr_out_val", {31'd0, out_val}, 32'd0);
        check("clr_grp_cnt", {16'd0, grp_cnt}, 32'd0);
        check("clr_err_cnt", {16'd0, err_cnt}, 32'd0);
        for (int k = 5; k < 9; k++) send(8'(k));
        in_val = 1'b0;
        check("clr_grp_cnt_after", {16'd0, grp_cnt}, 32'd1);
        expect_pop("clr_group", 32'h08070605, 1'b0);

        // Asynchronous reset with one group buffered and one partial group
        out_rdy = 1'b0;
        for (int k = 0; k < 4; k++) send(8'(k + 1));
        send(8'd9);
        in_val = 1'b0;
        check("ar_pre_val", {31'd0, out_val}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_out_val", {31'd0, out_val}, 32'd0);
        check("ar_out_data", out_data, 32'd0);
        check("ar_out_err", {31'd0, out_err}, 32'd0);
        check("ar_in_rdy", {31'd0, in_rdy}, 32'd1);
        check("ar_grp_cnt", {16'd0, grp_cnt}, 32'd0);
        check("ar_idx", {30'd0, dut.idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) send(8'd4 - 8'(k));
        in_val = 1'b0;
        expect_pop("ar_after", 32'h01020304, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sort_group_packer.md
# sort_group_packer

Downstream stage of the pipeline sorter. Consumes the sorted element stream one `DW`-bit value per handshake, reassembles every four consecutive elements into one packed group word, checks that each group is non-decreasing, and buffers completed groups in a small FIFO. Groups are presented to the consumer over a valid/ready interface.

## Interface

Parameters:
- `DW`, 8, element width; matches the sorter data width.
- `DEPTH`, 4, FIFO depth in groups; power of two, at least 2.
- `CW`, 16, width of the group and error counters.

Ports:
- `clk`, in, 1, clock.
- `rst_n`, in, 1, reset; asynchronous, active-low.
- `clr`, in, 1, synchronous clear: discards the partial group, empties the FIFO, zeroes the counters.
- `in_val`, in, 1, sorted element valid (driven by the sorter's `sort_val`).
- `in_data`, in, `DW`, sorted element.
- `in_rdy`, out, 1, stage can accept an element.
- `out_val`, out, 1, FIFO head group valid.
- `out_rdy`, in, 1, consumer accepts the head group.
- `out_data`, out, 4*`DW`, packed group; element k occupies `[k*DW +: DW]`.
- `out_err`, out, 1, head group was not non-decreasing.
- `grp_cnt`, out, `CW`, groups pushed into the FIFO since reset or `clr`; wraps.
- `err_cnt`, out, `CW`, groups pushed with the error flag set; wraps.

## Operation

Element acceptance:
- An element is accepted when `in_val && in_rdy`.
- Lane index `idx` is 2 bits, resets to 0, and increments on each accept. It wraps from 3 to 0.
- The accepted element is written to lane `idx` of the assembly register.

Order check (unsigned compare):
- On lanes 1..3, if `in_data` < the previous lane value, the sticky `grp_err` bit is set.
- Lane 0 does not compare. It loads `grp_err` with 0, overwriting any previous value.

Group completion:
- An accept on lane 3 pushes {assembled lanes 0..3, error} into the FIFO.
- The error bit pushed is `grp_err` OR the lane-3 comparison result.
- `grp_cnt` increments on every push. `err_cnt` increments on every push whose error bit is 1.

Ready:
- `in_rdy` = (`idx` != 3) || !`full`, where `full` means the FIFO holds `DEPTH` entries.
- Because of this, a push never occurs while the FIFO is full.
- Lanes 0..2 always accept, even when the FIFO is full.

FIFO:
- Read and write pointers are clog2(`DEPTH`)+1 bits wide.
- Empty: pointers are equal.
- Full: MSBs differ and the remaining bits are equal.
- Pop on `out_val && out_rdy`.
- A push and a pop in the same cycle are both performed, leaving occupancy unchanged.

Output:
- `out_val` = !empty.
- When the FIFO is non-empty, `out_data`/`out_err` come from the head entry.
- When the FIFO is empty, `out_data` = 0 and `out_err` = 0.

Clear:
- `clr` forces `idx` = 0, `grp_err` = 0, both pointers = 0 and both counters = 0.
- `clr` dominates a same-cycle accept, push or pop; none of them take effect.

## Timing

- Reset values:
  - `in_rdy` = 1
  - `out_val` = 0
  - `out_data` = 0
  - `out_err` = 0
  - `grp_cnt` = 0
  - `err_cnt` = 0
  - `idx` = 0
  - pointers = 0
- Latency: the lane-3 accept occurs in cycle N; `out_val` = 1 with that group's data in cycle N+1.
- Throughput: one element per cycle in; one group per cycle out.
- `in_rdy` and `out_val` are functions of registers only; there is no combinational path from `in_val` or `out_rdy`.
- Reset asserted mid-group or mid-drain: all state returns to the reset values immediately; partial groups and buffered groups are lost.
- Full FIFO with `idx` = 3: `in_rdy` = 0. It rises in the cycle after the first pop.

## Structure

- Shared package `sort_pkg` holds:
  - `GROUP_SIZE` = 4
  - a `ptr_w(depth)` function returning clog2(depth)+1
- Sub-module `sort_pack_fifo` provides the FIFO:
  - parameters: width 4*`DW`+1, `DEPTH`
  - push/pop/clr inputs; full/empty/head outputs
- The top level holds the lane index, assembly register, order checker and counters.

## Test plan

- Basic packing: reset, then send 3,7,7,200 with `out_rdy`=1. Required: `out_val` in the cycle after the 4th accept, `out_data` = 0xC8070703, `out_err` = 0, `grp_cnt` = 1.
- Order error: send 9,4,5,6. Required: `out_err` = 1, `err_cnt` = 1. Then send 0,0,0,0. Required: `out_err` = 0 for that group (sticky error cleared at lane 0).
- Backpressure to full (`DEPTH`=4, `out_rdy`=0): stream 20 elements.
  - Required: 4 groups stored, and the stream stops at element 19 with `in_rdy` = 0 and `idx` = 3.
  - Then raise `out_rdy` for one cycle. Required: `in_rdy` = 1 the next cycle, and a 5th push completes.
- Simultaneous push/pop: FIFO holds 2 groups, `out_rdy`=1, and a lane-3 accept happens in the same cycle. Required: occupancy stays 2 and the groups drain in order.
- Clear mid-group: accept 2 elements, then assert `clr` in a cycle where `in_val` = 1.
  - Required: that element is dropped, `idx` = 0, `out_val` = 0, counters = 0.
  - The next 4 elements form a clean group.
- Async reset while the FIFO is non-empty: all outputs return to their reset values without a clock edge.
